frame_serializer: RTL

//  Parallel-to-serial stage that sits directly upstream of the sequence detector and drives its bit_in.

---
 rtl/frame_serializer_pkg.sv | 12 +
 rtl/frame_serializer_mod_counter.sv | 38 +++
 rtl/frame_serializer.sv | 113 +++++++++++
 3 files changed

// File: rtl/frame_serializer_pkg.sv
// Shared types and constants for the frame serializer and its neighbours.
package frame_serializer_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Also used as the word width by the downstream sequence detector bench.
    localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/frame_serializer_mod_counter.sv
// Modulo counter with synchronous clear, enable and terminal-count decode.
module mod_counter #(
    parameter int unsigned Modulus = 8,
    localparam int unsigned CntW   = (Modulus > 1) ? $clog2(Modulus) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            en_i,
    output logic [CntW-1:0] cnt_o,
    output logic            tc_o
);

    localparam logic [CntW-1:0] LastCnt = CntW'(Modulus - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LastCnt);

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial stage: valid/ready word load, one bit per clock, gapless streaming.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int unsigned Width     = DefaultWidth,
    parameter bit          LsbFirst  = 1'b0,
    parameter bit          IdleLevel = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] load_data_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             bit_out_o,
    output logic             bit_valid_o,
    output logic             frame_first_o,
    output logic             frame_last_o,
    output logic             busy_o
);

    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

    if (Width < 2) begin : gen_width_check
        $error("frame_serializer: Width must be at least 2");
    end

    state_e           state_q, state_d;
    logic [Width-1:0] shift_q, shift_d;
    logic             bit_out_q, bit_out_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [CntW-1:0]  cnt;
    logic             cnt_tc;
    logic             accept;

    function automatic logic head_bit(logic [Width-1:0] w);
        return LsbFirst ? w[0] : w[Width-1];
    endfunction

    function automatic logic [Width-1:0] advance(logic [Width-1:0] w);
        return LsbFirst ? (w >> 1) : (w << 1);
    endfunction

    assign load_ready_o = rst_ni & ((state_q == StIdle) | ((state_q == StShift) & cnt_tc));
    assign accept       = load_valid_i & load_ready_o;

    // cnt tracks the index of the bit currently on bit_out_o.
    mod_counter #(
        .Modulus (Width)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (accept | (state_q == StIdle)),
        .en_i   (state_q == StShift),
        .cnt_o  (cnt),
        .tc_o   (cnt_tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_out_q <= IdleLevel;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_out_q <= bit_out_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StShift;
            StShift: if (cnt_tc && !accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are computed from the bit that shows next cycle.
    always_comb begin
        shift_d   = shift_q;
        bit_out_d = IdleLevel;
        valid_d   = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        if (accept) begin
            bit_out_d = head_bit(load_data_i);
            shift_d   = advance(load_data_i);
            valid_d   = 1'b1;
            first_d   = 1'b1;
        end else if ((state_q == StShift) && !cnt_tc) begin
            bit_out_d = head_bit(shift_q);
            shift_d   = advance(shift_q);
            valid_d   = 1'b1;
            last_d    = (cnt == CntW'(Width - 2));
        end
    end

    assign bit_out_o     = bit_out_q;
    assign bit_valid_o   = valid_q;
    assign frame_first_o = first_q;
    assign frame_last_o  = last_q;
    assign busy_o        = valid_q;

endmodule
